// File: rtl/puf_uart_pkg.sv
// Shared state encoding, baud-divider helper and 8N1 framing constants for the PUF UART host.
// Latency: none (types, constants and an elaboration-time function only).
// Backpressure: none.
package puf_uart_pkg;

  typedef enum logic [1:0] {IDLE, TX, RX, FIN} state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  function automatic int clks_per_bit(input int clk_fre_mhz, input int baud);
    return (clk_fre_mhz * 1000000) / baud;
  endfunction

endpackage

// File: rtl/puf_uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchroniser, falling-edge start detect, mid-bit sampling.
// Latency: byte_vld pulses one cycle after the mid-stop-bit sample.
// Backpressure: none; en low holds the receiver in hunt and drops line activity.
module puf_uart_rx_byte
  import puf_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 138
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 en,
  input  logic                 uart_rx,
  output logic                 start_det,
  output logic                 byte_vld,
  output logic [DATA_BITS-1:0] byte_dat,
  output logic                 stop_err
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int IW   = $clog2(DATA_BITS);

  typedef enum logic [1:0] {R_HUNT, R_START, R_DATA, R_STOP} rx_state_t;

  rx_state_t            rstate, rstate_nxt;
  logic [2:0]           sync_q;  // [1:0] synchroniser, [2] previous synced value
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_s, fall, bit_end, half_pt;

  assign rx_s    = sync_q[1];
  assign fall    = sync_q[2] & ~sync_q[1];
  assign bit_end = (cnt == CW'(CLKS_PER_BIT - 1));
  assign half_pt = (cnt == CW'(HALF - 1));

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) rstate <= R_HUNT;
    else          rstate <= rstate_nxt;
  end

  always_comb begin
    rstate_nxt = rstate;
    start_det  = 1'b0;
    case (rstate)
      R_HUNT: begin
        if (fall) begin
          rstate_nxt = R_START;
          start_det  = 1'b1;
        end
      end
      // A start bit that is high again at half-bit was a glitch
      R_START: if (half_pt) rstate_nxt = (rx_s == START_BIT) ? R_DATA : R_HUNT;
      R_DATA:  if (bit_end && bit_idx == IW'(DATA_BITS - 1)) rstate_nxt = R_STOP;
      R_STOP:  if (bit_end) rstate_nxt = R_HUNT;
      default: rstate_nxt = R_HUNT;
    endcase
    if (!en) begin
      rstate_nxt = R_HUNT;
      start_det  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync_q   <= '1;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      byte_vld <= 1'b0;
      byte_dat <= '0;
      stop_err <= 1'b0;
    end else begin
      sync_q   <= {sync_q[1:0], uart_rx};
      byte_vld <= 1'b0;
      if (rstate == R_HUNT || rstate_nxt != rstate || bit_end) cnt <= '0;
      else                                                     cnt <= cnt + 1'b1;
      if (rstate == R_START) bit_idx <= '0;
      if (rstate == R_DATA && bit_end) begin
        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
        bit_idx <= bit_idx + 1'b1;
      end
      if (en && rstate == R_STOP && bit_end) begin
        byte_vld <= 1'b1;
        byte_dat <= shreg;
        stop_err <= (rx_s != STOP_BIT);
      end
    end
  end

endmodule

// File: rtl/puf_uart_host.sv
// PUF host: sends a challenge 8N1 on uart_tx, gathers NUM_RESP reply bytes into resp_data (timeout via PUF_HOST_TIMEOUT_EN).
// Latency: Challenge_Bit/8*10 bit-times of TX, then RX until NUM_RESP good bytes; done one cycle later.
// Backpressure: start is ignored while busy; reply bytes cannot be stalled.
module puf_uart_host
  import puf_uart_pkg::*;
#(
  parameter int Challenge_Bit = 8,
  parameter int CLK_FRE       = 16,
  parameter int BAUD_RATE     = 115200,
  parameter int NUM_RESP      = 15,
  parameter int TIMEOUT_BITS  = 2000
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     start,
  input  logic [Challenge_Bit-1:0] challenge,
  input  logic                     uart_rx,
  output logic                     uart_tx,
  output logic                     busy,
  output logic                     done,
  output logic [8*NUM_RESP-1:0]    resp_data,
  output logic                     frame_err,
  output logic                     timeout
);

  localparam int CPB        = clks_per_bit(CLK_FRE, BAUD_RATE);
  localparam int NBYTES     = Challenge_Bit / 8;
  localparam int CW         = $clog2(CPB);
  localparam int BW         = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int KW         = $clog2(NUM_RESP + 1);
  localparam int FRAME_LAST = DATA_BITS + 1;

  if (Challenge_Bit == 0 || Challenge_Bit % 8 != 0 || TIMEOUT_BITS < 1) begin : g_bad_cfg
    $error("puf_uart_host: Challenge_Bit must be a non-zero multiple of 8, TIMEOUT_BITS >= 1");
  end

  state_t                 state, state_nxt;
  logic [Challenge_Bit-1:0] chal_sh;
  logic [CW-1:0]          tx_cnt;
  logic [3:0]             tx_pos;
  logic [BW-1:0]          tx_byte;
  logic [KW-1:0]          rx_k;
  logic                   start_acc, tx_bit_end, tx_last, rx_full, to_hit;
  logic                   byte_vld, stop_err, start_det;
  logic [DATA_BITS-1:0]   byte_dat;

  assign start_acc  = (state == IDLE) && start;
  assign tx_bit_end = (tx_cnt == CW'(CPB - 1));
  assign tx_last    = tx_bit_end && (tx_pos == 4'(FRAME_LAST)) && (tx_byte == BW'(NBYTES - 1));
  assign rx_full    = (state == RX) && byte_vld && !stop_err && (rx_k == KW'(NUM_RESP - 1));

  puf_uart_rx_byte #(
    .CLKS_PER_BIT(CPB)
  ) u_rx (
    .clk      (clk),
    .n_reset  (n_reset),
    .en       (state == RX),
    .uart_rx  (uart_rx),
    .start_det(start_det),
    .byte_vld (byte_vld),
    .byte_dat (byte_dat),
    .stop_err (stop_err)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = TX;
      TX: begin
        busy = 1'b1;
        if (tx_last) state_nxt = RX;
      end
      RX: begin
        busy = 1'b1;
        if (rx_full || to_hit) state_nxt = FIN;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Challenge bits shift out of chal_sh LSB-first, so bytes chain with no gap
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      uart_tx <= STOP_BIT;
      chal_sh <= '0;
      tx_cnt  <= '0;
      tx_pos  <= '0;
      tx_byte <= '0;
    end else if (start_acc) begin
      uart_tx <= START_BIT;
      chal_sh <= challenge;
      tx_cnt  <= '0;
      tx_pos  <= '0;
      tx_byte <= '0;
    end else if (state == TX) begin
      tx_cnt <= tx_bit_end ? '0 : tx_cnt + 1'b1;
      if (tx_bit_end) begin
        if (tx_pos == 4'(FRAME_LAST)) begin
          tx_pos  <= '0;
          tx_byte <= tx_byte + 1'b1;
          uart_tx <= tx_last ? STOP_BIT : START_BIT;
        end else if (tx_pos == 4'(DATA_BITS)) begin
          tx_pos  <= tx_pos + 1'b1;
          uart_tx <= STOP_BIT;
        end else begin
          tx_pos  <= tx_pos + 1'b1;
          uart_tx <= chal_sh[0];
          chal_sh <= chal_sh >> 1;
        end
      end
    end else begin
      uart_tx <= STOP_BIT;
    end
  end

  // Slots are only overwritten by good bytes; earlier results persist across starts
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      resp_data <= '0;
      rx_k      <= '0;
      frame_err <= 1'b0;
    end else if (start_acc) begin
      rx_k      <= '0;
      frame_err <= 1'b0;
    end else if (state == RX && byte_vld) begin
      if (stop_err) begin
        frame_err <= 1'b1;
      end else begin
        resp_data[{rx_k, 3'b000} +: DATA_BITS] <= byte_dat;
        rx_k <= rx_k + 1'b1;
      end
    end
  end

`ifdef PUF_HOST_TIMEOUT_EN
  localparam int TO_LIMIT = TIMEOUT_BITS * CPB;
  localparam int TW       = $clog2(TO_LIMIT + 1);

  logic [TW-1:0] to_cnt;

  assign to_hit = (state == RX) && (to_cnt == TW'(TO_LIMIT - 1));

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      if (state != RX || start_det) to_cnt <= '0;
      else                          to_cnt <= to_cnt + 1'b1;
      if (start_acc)                timeout <= 1'b0;
      else if (to_hit && !rx_full)  timeout <= 1'b1;
    end
  end
`else
  logic unused_start_det;

  assign unused_start_det = start_det;
  assign to_hit           = 1'b0;
  assign timeout          = 1'b0;
`endif

endmodule

// File: tb/tb_puf_uart_host.sv
// Self-checking bench for puf_uart_host: table-driven challenge frames plus randomized device replies.
// Reference model tracks expected response slots from the bytes the device model sends.
`timescale 1ns/1ps
module tb_puf_uart_host;

  localparam int NR  = 15;
  localparam int TOB = 40;
  localparam int CPB = 16 * 1000000 / 115200;

  logic            clk, n_reset, start, uart_rx;
  logic [7:0]      challenge;
  logic            uart_tx, busy, done, frame_err, timeout;
  logic [8*NR-1:0] resp_data;

  puf_uart_host #(
    .Challenge_Bit(8),
    .CLK_FRE      (16),
    .BAUD_RATE    (115200),
    .NUM_RESP     (NR),
    .TIMEOUT_BITS (TOB)
  ) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .start    (start),
    .challenge(challenge),
    .uart_rx  (uart_rx),
    .uart_tx  (uart_tx),
    .busy     (busy),
    .done     (done),
    .resp_data(resp_data),
    .frame_err(frame_err),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #31.25 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [8*NR-1:0] m_resp;
  int              m_k;

  logic            d_ok;
  int              d_cyc;
  logic [8*NR-1:0] d_resp;
  logic            d_fe, d_to, d_busy;

  typedef struct {
    logic [7:0] ch;
    logic [9:0] frame;
  } vec_t;
  vec_t tbl[4];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] model_frame(input logic [7:0] ch);
    logic [9:0] f;
    f[0] = 1'b0;
    f[9] = 1'b1;
    for (int i = 0; i < 8; i++) f[i+1] = ch[i];
    return f;
  endfunction

  // Launch a transaction and sample each TX bit just after it starts and just before it ends
  task automatic start_txn(input logic [7:0] ch, output logic [9:0] sa, output logic [9:0] sb);
    @(negedge clk);
    check("busy_before_start", 128'(busy), 128'(0));
    challenge = ch;
    start     = 1'b1;
    m_k       = 0;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_after_start", 128'(busy), 128'(1));
    for (int i = 0; i < 10; i++) begin
      sa[i] = uart_tx;
      repeat (CPB - 1) @(posedge clk);
      #1 sb[i] = uart_tx;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input int nbits);
    logic [9:0] f;
    f = {stop_b, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      uart_rx = f[i];
      repeat (CPB) @(posedge clk);
    end
    uart_rx = 1'b1;
    if (nbits == 10 && !stop_b) repeat (CPB) @(posedge clk);
  endtask

  task automatic dev_byte(input logic [7:0] d, input logic stop_b);
    send_frame(d, stop_b, 10);
    if (stop_b) begin
      m_resp[8*m_k +: 8] = d;
      m_k++;
    end
  endtask

  task automatic wait_done(input int budget);
    d_ok  = 1'b0;
    d_cyc = 0;
    for (int i = 0; i < budget && !d_ok; i++) begin
      @(negedge clk);
      d_cyc = i + 1;
      if (done) begin
        d_ok   = 1'b1;
        d_resp = resp_data;
        d_fe   = frame_err;
        d_to   = timeout;
        d_busy = busy;
      end
    end
    check("done_seen", 128'(d_ok), 128'(1));
    if (d_ok) begin
      @(negedge clk);
      check("done_one_cycle", 128'(done), 128'(0));
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    n_reset = 1'b0;
    #1;
    check("rst_uart_tx", 128'(uart_tx), 128'(1));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_resp", 128'(resp_data), 128'(0));
    check("rst_frame_err", 128'(frame_err), 128'(0));
    check("rst_timeout", 128'(timeout), 128'(0));
    m_resp  = '0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
  endtask

  initial begin
    #(150000 * 62.5);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  sa, sb;
    logic [7:0]  ch;
    logic [7:0]  rnd[NR];
    int          bad_pos;

    tbl[0] = '{8'hA5, 10'h34A};
    tbl[1] = '{8'h00, 10'h200};
    tbl[2] = '{8'hFF, 10'h3FE};
    tbl[3] = '{8'h3C, 10'h278};

    n_reset   = 1'b0;
    start     = 1'b0;
    challenge = '0;
    uart_rx   = 1'b1;
    m_resp    = '0;
    m_k       = 0;

    #300;
    check("reset_uart_tx", 128'(uart_tx), 128'(1));
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_done", 128'(done), 128'(0));
    check("reset_resp", 128'(resp_data), 128'(0));
    check("reset_frame_err", 128'(frame_err), 128'(0));
    check("reset_timeout", 128'(timeout), 128'(0));
    @(negedge clk);
    n_reset = 1'b1;

    // Challenge frames from the table, each aborted by reset once RX is reached
    for (int e = 0; e < 4; e++) begin
      start_txn(tbl[e].ch, sa, sb);
      check($sformatf("frame_head_%0d", e), 128'(sa), 128'(tbl[e].frame));
      check($sformatf("frame_tail_%0d", e), 128'(sb), 128'(tbl[e].frame));
      check($sformatf("busy_in_rx_%0d", e), 128'(busy), 128'(1));
      pulse_reset();
    end

    // Reset while a low data bit is on the line returns uart_tx high at once
    @(negedge clk);
    challenge = 8'h00;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (200) @(negedge clk);
    check("tx_low_mid_frame", 128'(uart_tx), 128'(0));
    pulse_reset();

    // Clean transaction: device replies 1..15; a start pulse during RX is ignored
    ch = 8'($urandom);
    start_txn(ch, sa, sb);
    check("main_frame_head", 128'(sa), 128'(model_frame(ch)));
    check("main_frame_tail", 128'(sb), 128'(model_frame(ch)));
    @(negedge clk);
    challenge = ~ch;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_ignores_start", 128'(busy), 128'(1));
    fork
      for (int k = 1; k <= NR; k++) dev_byte(8'(k), 1'b1);
      wait_done(NR * 10 * CPB + 4000);
    join
    check("main_resp", 128'(d_resp), 128'(m_resp));
    check("main_frame_err", 128'(d_fe), 128'(0));
    check("main_timeout", 128'(d_to), 128'(0));
    check("main_busy_at_done", 128'(d_busy), 128'(0));

    // Reset in the middle of byte 7; slots 0..5 must already be visible
    ch = 8'($urandom);
    start_txn(ch, sa, sb);
    check("rst7_frame", 128'(sb), 128'(model_frame(ch)));
    for (int k = 1; k <= 6; k++) dev_byte(8'($urandom), 1'b1);
    repeat (3) @(posedge clk);
    check("partial_slots", 128'(resp_data), 128'(m_resp));
    send_frame(8'd7, 1'b1, 5);
    pulse_reset();

    // Random reply bytes with one bad-stop byte at a random position
    ch = 8'($urandom);
    bad_pos = $urandom_range(0, NR - 1);
    for (int k = 0; k < NR; k++) rnd[k] = 8'($urandom);
    start_txn(ch, sa, sb);
    check("rand_frame", 128'(sb), 128'(model_frame(ch)));
    fork
      for (int k = 0; k < NR; k++) begin
        if (k == bad_pos) dev_byte(8'($urandom), 1'b0);
        dev_byte(rnd[k], 1'b1);
      end
      wait_done((NR + 2) * 10 * CPB + 4000);
    join
    check("rand_resp", 128'(d_resp), 128'(m_resp));
    check("rand_frame_err", 128'(d_fe), 128'(1));
    check("rand_timeout", 128'(d_to), 128'(0));

`ifdef PUF_HOST_TIMEOUT_EN
    // Only 5 replies: transaction ends by timeout, slots 5..14 keep earlier bytes
    ch = 8'($urandom);
    start_txn(ch, sa, sb);
    for (int k = 1; k <= 5; k++) dev_byte(8'(k), 1'b1);
    wait_done(TOB * CPB + 3000);
    check("to_flag", 128'(d_to), 128'(1));
    check("to_resp", 128'(d_resp), 128'(m_resp));
    check("to_frame_err_cleared", 128'(d_fe), 128'(0));
    check("to_latency_window",
          128'(d_cyc >= TOB * CPB - 10 * CPB - 10 && d_cyc <= TOB * CPB - 10 * CPB + 10), 128'(1));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
